maple_frame_assembler: RTL and testbench

MAPLE_FRAME_ASSEMBLER -- requirements
Module: maple_frame_assembler

---
 rtl/maple_frame_assembler_if.sv | 34 +++
 rtl/maple_frame_assembler.sv | 209 ++++++++++++++++++++
 tb/tb_maple_frame_assembler.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maple_frame_assembler_if.sv
// Receiver-side byte strobes, payload stream and frame/header status of the Maple frame assembler.
interface maple_frame_assembler_if;
  logic       busy;
  logic       write;
  logic [7:0] data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       hdr_valid;
  logic [7:0] hdr_length;
  logic [7:0] hdr_sender;
  logic [7:0] hdr_recipient;
  logic [7:0] hdr_command;
  logic       frame_done;
  logic       frame_ok;
  logic       err_crc;
  logic       err_length;
  logic       err_overflow;

  modport master (
    output busy, write, data, out_ready,
    input  out_valid, out_data, out_last, hdr_valid,
    input  hdr_length, hdr_sender, hdr_recipient, hdr_command,
    input  frame_done, frame_ok, err_crc, err_length, err_overflow
  );

  modport slave (
    input  busy, write, data, out_ready,
    output out_valid, out_data, out_last, hdr_valid,
    output hdr_length, hdr_sender, hdr_recipient, hdr_command,
    output frame_done, frame_ok, err_crc, err_length, err_overflow
  );
endinterface

// File: rtl/maple_frame_assembler.sv
// Splits a Maple bus frame into header fields and a payload FIFO stream,
// checking the XOR checksum and frame length against the busy envelope.
module maple_frame_assembler #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic                    clk,
  input logic                    reset,
  maple_frame_assembler_if.slave bus
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned PCW = 10;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CRC     = 3'd3;
  localparam logic [2:0] S_TRAIL   = 3'd4;

  logic [2:0]     state_q, state_d;
  logic           busy_q;
  logic [1:0]     hcnt_q, hcnt_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [7:0]     xor_q, xor_d;
  logic [7:0]     hdr_length_q, hdr_length_d;
  logic [7:0]     hdr_sender_q, hdr_sender_d;
  logic [7:0]     hdr_recipient_q, hdr_recipient_d;
  logic [7:0]     hdr_command_q, hdr_command_d;
  logic           hdr_valid_q, hdr_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_ok_q, frame_ok_d;
  logic           err_crc_q, err_crc_d;
  logic           err_length_q, err_length_d;
  logic           err_overflow_q, err_overflow_d;

  logic [8:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           rise_c, fall_c, acc_c;
  logic           push_req_c, push_last_c, push_c;
  logic           pop_c, full_c;
  logic [PCW-1:0] plast_c;

  assign rise_c  = bus.busy & ~busy_q;
  assign fall_c  = ~bus.busy & busy_q;
  assign acc_c   = bus.write & (state_q != S_IDLE);
  assign full_c  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop_c   = (cnt_q != '0) & bus.out_ready;
  assign plast_c = PCW'({hdr_length_q, 2'b00}) - PCW'(1);

  // Frame sequencing: the accepted byte is processed before end of frame is evaluated
  always_comb begin
    state_d         = state_q;
    hcnt_d          = hcnt_q;
    pcnt_d          = pcnt_q;
    xor_d           = xor_q;
    hdr_length_d    = hdr_length_q;
    hdr_sender_d    = hdr_sender_q;
    hdr_recipient_d = hdr_recipient_q;
    hdr_command_d   = hdr_command_q;
    hdr_valid_d     = 1'b0;
    frame_done_d    = 1'b0;
    frame_ok_d      = frame_ok_q;
    err_crc_d       = err_crc_q;
    err_length_d    = err_length_q;
    err_overflow_d  = err_overflow_q;
    push_req_c      = 1'b0;
    push_last_c     = 1'b0;
    push_c          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise_c) begin
          state_d        = S_HEADER;
          hcnt_d         = '0;
          pcnt_d         = '0;
          xor_d          = '0;
          frame_ok_d     = 1'b0;
          err_crc_d      = 1'b0;
          err_length_d   = 1'b0;
          err_overflow_d = 1'b0;
        end
      end
      S_HEADER: begin
        if (acc_c) begin
          xor_d  = xor_q ^ bus.data;
          hcnt_d = hcnt_q + 2'd1;
          case (hcnt_q)
            2'd0:    hdr_length_d    = bus.data;
            2'd1:    hdr_sender_d    = bus.data;
            2'd2:    hdr_recipient_d = bus.data;
            default: begin
              hdr_command_d = bus.data;
              hdr_valid_d   = 1'b1;
              state_d       = (hdr_length_q != 8'd0) ? S_PAYLOAD : S_CRC;
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (acc_c) begin
          xor_d       = xor_q ^ bus.data;
          pcnt_d      = pcnt_q + PCW'(1);
          push_req_c  = 1'b1;
          push_last_c = (pcnt_q == plast_c);
          if (push_last_c) state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (acc_c) begin
          if (bus.data != xor_q) err_crc_d = 1'b1;
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (acc_c) err_length_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A full FIFO still takes the byte when the head leaves in the same cycle
    push_c = push_req_c & (~full_c | pop_c);
    if (push_req_c & ~push_c) err_overflow_d = 1'b1;

    if (fall_c && (state_q != S_IDLE)) begin
      if ((state_d == S_HEADER) || (state_d == S_PAYLOAD) || (state_d == S_CRC))
        err_length_d = 1'b1;
      frame_done_d = 1'b1;
      frame_ok_d   = ~(err_crc_d | err_length_d | err_overflow_d);
      state_d      = S_IDLE;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // busy_q resets high so a busy level already present at release is not taken as a frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b1;
      hcnt_q          <= '0;
      pcnt_q          <= '0;
      xor_q           <= '0;
      hdr_length_q    <= '0;
      hdr_sender_q    <= '0;
      hdr_recipient_q <= '0;
      hdr_command_q   <= '0;
      hdr_valid_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_ok_q      <= 1'b0;
      err_crc_q       <= 1'b0;
      err_length_q    <= 1'b0;
      err_overflow_q  <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= bus.busy;
      hcnt_q          <= hcnt_d;
      pcnt_q          <= pcnt_d;
      xor_q           <= xor_d;
      hdr_length_q    <= hdr_length_d;
      hdr_sender_q    <= hdr_sender_d;
      hdr_recipient_q <= hdr_recipient_d;
      hdr_command_q   <= hdr_command_d;
      hdr_valid_q     <= hdr_valid_d;
      frame_done_q    <= frame_done_d;
      frame_ok_q      <= frame_ok_d;
      err_crc_q       <= err_crc_d;
      err_length_q    <= err_length_d;
      err_overflow_q  <= err_overflow_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {push_last_c, bus.data};
  end

  assign bus.out_valid     = (cnt_q != '0);
  assign bus.out_data      = mem_q[rd_ptr_q][7:0];
  assign bus.out_last      = (cnt_q != '0) & mem_q[rd_ptr_q][8];
  assign bus.hdr_valid     = hdr_valid_q;
  assign bus.hdr_length    = hdr_length_q;
  assign bus.hdr_sender    = hdr_sender_q;
  assign bus.hdr_recipient = hdr_recipient_q;
  assign bus.hdr_command   = hdr_command_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_ok      = frame_ok_q;
  assign bus.err_crc       = err_crc_q;
  assign bus.err_length    = err_length_q;
  assign bus.err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_maple_frame_assembler.sv
// Self-checking bench for maple_frame_assembler: directed frames plus randomized
// frames scored against a queue-based frame model.
module tb_maple_frame_assembler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  maple_frame_assembler_if ifc ();

  maple_frame_assembler #(.FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int checks   = 0;
  int failures = 0;

  // 0: hold out_ready low, 1: always ready, 2: random ready
  int ready_mode = 0;

  logic [8:0] got_q[$];
  int         hv_cnt   = 0;
  int         done_cnt = 0;
  logic [31:0] hv_fields;
  logic       dn_ok, dn_crc, dn_len, dn_ovf;

  always @(posedge clk) begin
    #1;
    ifc.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  // Record pops, header pulses and frame completions as the consumer would see them
  always @(negedge clk) begin
    if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1)
      got_q.push_back({ifc.out_last, ifc.out_data});
    if (ifc.hdr_valid === 1'b1) begin
      hv_cnt++;
      hv_fields = {ifc.hdr_length, ifc.hdr_sender, ifc.hdr_recipient, ifc.hdr_command};
    end
    if (ifc.frame_done === 1'b1) begin
      done_cnt++;
      dn_ok  = ifc.frame_ok;
      dn_crc = ifc.err_crc;
      dn_len = ifc.err_length;
      dn_ovf = ifc.err_overflow;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] b[$], input bit same_fall, input int gap_max);
    int n;
    ifc.busy = 1'b1;
    step();
    foreach (b[i]) begin
      ifc.write = 1'b1;
      ifc.data  = b[i];
      if (same_fall && i == b.size() - 1) ifc.busy = 1'b0;
      step();
      ifc.write = 1'b0;
      if (!(same_fall && i == b.size() - 1)) begin
        n = $urandom_range(0, gap_max);
        for (int g = 0; g < n; g++) step();
      end
    end
    ifc.busy = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic drain(output bit timed_out);
    ready_mode = 1;
    step();
    for (int c = 0; c < 64 && ifc.out_valid; c++) step();
    timed_out  = ifc.out_valid;
    ready_mode = 0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    ifc.busy   = 1'b0;
    ifc.write  = 1'b0;
    ifc.data   = 8'h00;
    repeat (3) step();
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_last !== 1'b0) begin
      failures++; $display("FAIL reset_fifo got valid=%b last=%b exp 0 0", ifc.out_valid, ifc.out_last);
    end
    checks++;
    if ({ifc.hdr_valid, ifc.frame_done, ifc.frame_ok} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got hv=%b fd=%b ok=%b exp 000", ifc.hdr_valid, ifc.frame_done, ifc.frame_ok);
    end
    checks++;
    if ({ifc.err_crc, ifc.err_length, ifc.err_overflow} !== 3'b000) begin
      failures++; $display("FAIL reset_err got %b%b%b exp 000", ifc.err_crc, ifc.err_length, ifc.err_overflow);
    end
    checks++;
    if ({ifc.hdr_length, ifc.hdr_sender, ifc.hdr_recipient, ifc.hdr_command} !== 32'h0) begin
      failures++; $display("FAIL reset_hdr got %h%h%h%h exp 00000000", ifc.hdr_length, ifc.hdr_sender, ifc.hdr_recipient, ifc.hdr_command);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_known_frame(input logic [7:0] crc, input bit exp_ok, input bit exp_crc);
    logic [7:0] b[$];
    logic [8:0] exp[$];
    int hv0, d0;
    bit to;
    b   = {8'h01, 8'h00, 8'h20, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, crc};
    exp = {9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD};
    got_q.delete();
    hv0 = hv_cnt; d0 = done_cnt; ready_mode = 0;
    run_frame(b, 1'b0, 2);
    checks++;
    if (hv_cnt - hv0 != 1 || hv_fields !== 32'h01002001) begin
      failures++; $display("FAIL known_hdr pulses=%0d fields=%h exp 1 01002001", hv_cnt - hv0, hv_fields);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++; $display("FAIL known_done pulses=%0d exp 1", done_cnt - d0);
    end
    checks++;
    if (dn_ok !== exp_ok || dn_crc !== exp_crc || dn_len !== 1'b0 || dn_ovf !== 1'b0) begin
      failures++; $display("FAIL known_status ok=%b crc=%b len=%b ovf=%b exp %b %b 0 0", dn_ok, dn_crc, dn_len, dn_ovf, exp_ok, exp_crc);
    end
    checks++;
    if (ifc.frame_ok !== exp_ok || ifc.out_valid !== 1'b1) begin
      failures++; $display("FAIL known_hold ok=%b valid=%b exp %b 1", ifc.frame_ok, ifc.out_valid, exp_ok);
    end
    drain(to);
    checks++;
    if (to || got_q.size() != exp.size()) begin
      failures++; $display("FAIL known_count got=%0d timeout=%b exp %0d", got_q.size(), to, exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (got_q[i] !== exp[i]) begin
          failures++; $display("FAIL known_byte%0d got=%h exp=%h", i, got_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] b[$];
    int hv0, d0;
    b = {8'h00, 8'h00, 8'h20, 8'h01, 8'h21};
    got_q.delete();
    hv0 = hv_cnt; d0 = done_cnt; ready_mode = 0;
    run_frame(b, 1'b0, 1);
    checks++;
    if (hv_cnt - hv0 != 1 || hv_fields !== 32'h00002001) begin
      failures++; $display("FAIL zero_hdr pulses=%0d fields=%h exp 1 00002001", hv_cnt - hv0, hv_fields);
    end
    checks++;
    if (done_cnt - d0 != 1 || dn_ok !== 1'b1) begin
      failures++; $display("FAIL zero_ok done=%0d ok=%b exp 1 1", done_cnt - d0, dn_ok);
    end
    checks++;
    if (ifc.out_valid !== 1'b0 || got_q.size() != 0) begin
      failures++; $display("FAIL zero_nopush valid=%b popped=%0d exp 0 0", ifc.out_valid, got_q.size());
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] b[$];
    int d0;
    bit to;
    b = {8'h01, 8'h00, 8'h20, 8'h01, 8'h11, 8'h22};
    got_q.delete();
    d0 = done_cnt; ready_mode = 0;
    run_frame(b, 1'b0, 1);
    checks++;
    if (done_cnt - d0 != 1 || dn_len !== 1'b1 || dn_ok !== 1'b0) begin
      failures++; $display("FAIL short_status done=%0d len=%b ok=%b exp 1 1 0", done_cnt - d0, dn_len, dn_ok);
    end
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_last !== 1'b0) begin
      failures++; $display("FAIL short_head valid=%b last=%b exp 1 0", ifc.out_valid, ifc.out_last);
    end
    drain(to);
    checks++;
    if (to || got_q.size() != 2 || got_q[0] !== 9'h011 || got_q[1] !== 9'h022) begin
      failures++; $display("FAIL short_bytes count=%0d timeout=%b exp 2 bytes 011 022", got_q.size(), to);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b[$];
    logic [7:0] x;
    int d0;
    bit to;
    b = {8'h05, 8'h00, 8'h20, 8'h01};
    for (int i = 0; i < 20; i++) b.push_back(8'(i * 7 + 3));
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    b.push_back(x);
    got_q.delete();
    d0 = done_cnt; ready_mode = 0;
    run_frame(b, 1'b0, 0);
    checks++;
    if (done_cnt - d0 != 1 || dn_ovf !== 1'b1 || dn_ok !== 1'b0) begin
      failures++; $display("FAIL ovf_status done=%0d ovf=%b ok=%b exp 1 1 0", done_cnt - d0, dn_ovf, dn_ok);
    end
    checks++;
    if (dn_crc !== 1'b0 || dn_len !== 1'b0) begin
      failures++; $display("FAIL ovf_other crc=%b len=%b exp 0 0", dn_crc, dn_len);
    end
    drain(to);
    checks++;
    if (to || got_q.size() != 16) begin
      failures++; $display("FAIL ovf_count got=%0d timeout=%b exp 16", got_q.size(), to);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[i] !== {1'b0, b[4 + i]}) begin
          failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got_q[i], {1'b0, b[4 + i]});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    int d0;
    b = {8'h01, 8'h00, 8'h20, 8'h01, 8'h55, 8'h66};
    d0 = done_cnt; ready_mode = 0;
    ifc.busy = 1'b1;
    step();
    foreach (b[i]) begin
      ifc.write = 1'b1; ifc.data = b[i];
      step();
    end
    ifc.write = 1'b0;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_last !== 1'b0) begin
      failures++; $display("FAIL rstmid_fifo valid=%b last=%b exp 0 0", ifc.out_valid, ifc.out_last);
    end
    checks++;
    if ({ifc.hdr_length, ifc.hdr_sender, ifc.hdr_recipient, ifc.hdr_command} !== 32'h0 ||
        {ifc.hdr_valid, ifc.frame_done, ifc.frame_ok, ifc.err_crc, ifc.err_length, ifc.err_overflow} !== 6'b0) begin
      failures++; $display("FAIL rstmid_out hdr=%h%h%h%h flags=%b%b%b%b%b%b exp all 0", ifc.hdr_length, ifc.hdr_sender,
                           ifc.hdr_recipient, ifc.hdr_command, ifc.hdr_valid, ifc.frame_done, ifc.frame_ok,
                           ifc.err_crc, ifc.err_length, ifc.err_overflow);
    end
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
    ifc.busy = 1'b0;
    repeat (3) step();
    checks++;
    if (done_cnt != d0 || ifc.out_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_quiet done=%0d valid=%b exp 0 0", done_cnt - d0, ifc.out_valid);
    end
    test_known_frame(8'h20, 1'b1, 1'b0);
  endtask

  task automatic test_random(input int nframes);
    for (int f = 0; f < nframes; f++) begin
      logic [7:0]  b[$];
      logic [8:0]  exp[$];
      logic [7:0]  x;
      logic [31:0] hdr;
      int L, n, k, mode, hv0, d0;
      bit crc_good, same_fall, exp_crc, exp_len, exp_ok, to;
      b.delete(); exp.delete();
      L    = $urandom_range(0, 4);
      n    = L * 4;
      mode = $urandom_range(0, 3);   // 0 good frame, 1 extra trailing byte, 2 truncated payload, 3 missing CRC
      if (mode == 2 && L == 0) mode = 3;
      k    = (mode == 2) ? $urandom_range(0, n - 1) : n;
      b    = {8'(L), 8'($urandom), 8'($urandom), 8'($urandom)};
      hdr  = {b[0], b[1], b[2], b[3]};
      for (int i = 0; i < k; i++) begin
        b.push_back(8'($urandom));
        exp.push_back({1'(i == n - 1), b[4 + i]});
      end
      x = 8'h00;
      foreach (b[i]) x ^= b[i];
      crc_good = 1'($urandom_range(0, 1));
      if (mode <= 1) b.push_back(crc_good ? x : x ^ 8'($urandom_range(1, 255)));
      if (mode == 1) b.push_back(8'($urandom));
      exp_crc   = (mode <= 1) && !crc_good;
      exp_len   = (mode >= 1);
      exp_ok    = !(exp_crc || exp_len);
      same_fall = (b.size() > 4) && ($urandom_range(0, 1) == 1);
      got_q.delete();
      hv0 = hv_cnt; d0 = done_cnt; ready_mode = 2;
      run_frame(b, same_fall, 2);
      drain(to);
      checks++;
      if (hv_cnt - hv0 != 1 || hv_fields !== hdr) begin
        failures++; $display("FAIL rand%0d_hdr pulses=%0d fields=%h exp 1 %h", f, hv_cnt - hv0, hv_fields, hdr);
      end
      checks++;
      if (done_cnt - d0 != 1) begin
        failures++; $display("FAIL rand%0d_done pulses=%0d exp 1", f, done_cnt - d0);
      end
      checks++;
      if (dn_ok !== exp_ok || dn_crc !== exp_crc || dn_len !== exp_len || dn_ovf !== 1'b0) begin
        failures++; $display("FAIL rand%0d_status ok=%b crc=%b len=%b ovf=%b exp %b %b %b 0 (mode %0d)",
                             f, dn_ok, dn_crc, dn_len, dn_ovf, exp_ok, exp_crc, exp_len, mode);
      end
      checks++;
      if (to || got_q.size() != exp.size()) begin
        failures++; $display("FAIL rand%0d_count got=%0d timeout=%b exp %0d", f, got_q.size(), to, exp.size());
      end else begin
        foreach (exp[i]) begin
          checks++;
          if (got_q[i] !== exp[i]) begin
            failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", f, i, got_q[i], exp[i]);
          end
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    ifc.busy  = 1'b0;
    ifc.write = 1'b0;
    ifc.data  = 8'h00;
    test_reset();
    test_known_frame(8'h20, 1'b1, 1'b0);
    test_known_frame(8'h21, 1'b0, 1'b1);
    test_zero_len();
    test_short_frame();
    test_overflow();
    test_reset_mid();
    test_random(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
